// File: rtl/jtag_master.sv
`timescale 1ns/1ps
`default_nettype none
// -----------------------------------------------------------------------------
// jtag_master: turns reset / shift-IR / shift-DR / idle-clock commands into
//              TAP pin sequences (TCK, TMS, TDI, TRST) and captures TDO.
// Revision: 1.0
// -----------------------------------------------------------------------------
module jtag_master #(
    parameter int CLK_DIV = 2,
    parameter int IR_LEN  = 4,
    parameter int DR_MAX  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [5:0]        cmd_len,
    input  logic [DR_MAX-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DR_MAX-1:0] rsp_data,
    output logic              busy,
    output logic              TCK,
    output logic              TMS,
    output logic              TDI,
    output logic              TRST,
    input  logic              TDO
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = $clog2(DR_MAX);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_DR    = 2'd2;
    localparam logic [1:0] OP_IDLE  = 2'd3;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_HDR   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_TRL   = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    state_t            state;
    logic [5:0]        cnt;
    logic [DW-1:0]     div;
    logic [1:0]        op;
    logic [5:0]        nbits;
    logic [DR_MAX-1:0] data;

    state_t     nx_state;
    logic [5:0] nx_cnt;
    logic       nx_tms, nx_trst, nx_tdi;

    state_t     st_state;
    logic [5:0] st_nbits;
    logic       st_tms, st_trst;

    function automatic logic [5:0] hdr_len(input logic [1:0] o);
        case (o)
            OP_RESET: return 6'd6;
            OP_IR:    return 6'd4;
            OP_DR:    return 6'd3;
            default:  return 6'd0;
        endcase
    endfunction

    function automatic logic hdr_tms(input logic [1:0] o, input logic [5:0] c);
        case (o)
            OP_RESET: return c < 6'd5;
            OP_IR:    return c < 6'd2;
            OP_DR:    return c == 6'd0;
            default:  return 1'b0;
        endcase
    endfunction

    // Position and pin values of the TCK period that follows the current one.
    always_comb begin
        nx_state = state;
        nx_cnt   = cnt + 6'd1;
        case (state)
            ST_INIT:  if (cnt == 6'd5) nx_state = ST_IDLE;
            ST_HDR:   if (cnt == hdr_len(op) - 6'd1) begin
                          nx_cnt   = 6'd0;
                          nx_state = (op == OP_RESET) ? ST_RESP : ST_SHIFT;
                      end
            ST_SHIFT: if (cnt == nbits - 6'd1) begin
                          nx_cnt   = 6'd0;
                          nx_state = (op == OP_IDLE) ? ST_RESP : ST_TRL;
                      end
            ST_TRL:   if (cnt == 6'd1) begin
                          nx_cnt   = 6'd0;
                          nx_state = ST_RESP;
                      end
            default:  ;
        endcase

        nx_tms  = 1'b0;
        nx_trst = 1'b1;
        nx_tdi  = 1'b0;
        case (nx_state)
            ST_INIT: begin
                nx_tms  = nx_cnt < 6'd5;
                nx_trst = !(nx_cnt < 6'd5);
            end
            ST_HDR: begin
                nx_tms  = hdr_tms(op, nx_cnt);
                nx_trst = !(op == OP_RESET && nx_cnt < 6'd5);
            end
            ST_SHIFT: if (op != OP_IDLE) begin
                nx_tms = (nx_cnt == nbits - 6'd1);
                nx_tdi = data[nx_cnt[IW-1:0]];
            end
            ST_TRL:  nx_tms = (nx_cnt == 6'd0);
            default: ;
        endcase
    end

    // First period of a freshly accepted command.
    always_comb begin
        case (cmd_op)
            OP_IR:   st_nbits = 6'(IR_LEN);
            OP_DR:   st_nbits = (cmd_len == 6'd0) ? 6'd1 :
                                (cmd_len > 6'(DR_MAX)) ? 6'(DR_MAX) : cmd_len;
            OP_IDLE: st_nbits = cmd_len;
            default: st_nbits = 6'd0;
        endcase
        st_state = ST_HDR;
        st_tms   = hdr_tms(cmd_op, 6'd0);
        st_trst  = (cmd_op != OP_RESET);
        if (cmd_op == OP_IDLE) begin
            st_state = (cmd_len == 6'd0) ? ST_RESP : ST_SHIFT;
            st_tms   = 1'b0;
            st_trst  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            cnt       <= 6'd0;
            div       <= '0;
            op        <= OP_RESET;
            nbits     <= 6'd0;
            data      <= '0;
            TCK       <= 1'b0;
            TMS       <= 1'b1;
            TDI       <= 1'b0;
            TRST      <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (cmd_valid) begin
                    op        <= cmd_op;
                    data      <= cmd_data;
                    nbits     <= st_nbits;
                    rsp_data  <= '0;
                    cmd_ready <= 1'b0;
                    busy      <= 1'b1;
                    state     <= st_state;
                    cnt       <= 6'd0;
                    div       <= '0;
                    TMS       <= st_tms;
                    TRST      <= st_trst;
                    TDI       <= 1'b0;
                    if (st_state == ST_RESP) rsp_valid <= 1'b1;
                end
                ST_RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    if (div != DIV_LAST) begin
                        div <= div + DW'(1);
                    end else begin
                        div <= '0;
                        if (!TCK) begin
                            TCK <= 1'b1;
                            if (state == ST_SHIFT && op != OP_IDLE)
                                rsp_data[cnt[IW-1:0]] <= TDO;
                        end else begin
                            // Period boundary: TCK falls and the next bits launch together.
                            TCK   <= 1'b0;
                            state <= nx_state;
                            cnt   <= nx_cnt;
                            TMS   <= nx_tms;
                            TRST  <= nx_trst;
                            TDI   <= nx_tdi;
                            if (nx_state == ST_IDLE) begin
                                cmd_ready <= 1'b1;
                                busy      <= 1'b0;
                            end
                            if (nx_state == ST_RESP) rsp_valid <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtag_master.sv
`timescale 1ns/1ps
`default_nettype none
// -----------------------------------------------------------------------------
// tb_jtag_master: period-level reference of the expected TAP walk per command.
// Revision: 1.0
// -----------------------------------------------------------------------------
module tb_jtag_master;

    localparam int CLK_DIV = 2;
    localparam int IR_LEN  = 4;
    localparam int DR_MAX  = 32;

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_DR    = 2'd2;
    localparam logic [1:0] OP_IDLE  = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        rsp_ready = 1'b1;
    logic [1:0]  cmd_op = 2'd0;
    logic [5:0]  cmd_len = 6'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        cmd_ready, rsp_valid, busy;
    logic [31:0] rsp_data;
    logic        TCK, TMS, TDI, TRST, TDO;
    logic        loop_mode = 1'b1;
    logic [15:0] lfsr = 16'hACE1;

    assign TDO = loop_mode ? TDI : lfsr[0];
    always @(negedge TCK) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    always #5 clk = ~clk;

    jtag_master #(.CLK_DIV(CLK_DIV), .IR_LEN(IR_LEN), .DR_MAX(DR_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .TCK(TCK), .TMS(TMS), .TDI(TDI), .TRST(TRST), .TDO(TDO)
    );

    int nchecks = 0;
    int nerrors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic tms;
        logic tdi;
        logic trst;
        logic shift;
        logic first;
        int   idx;
    } per_t;

    per_t        exp_q[$];
    logic [31:0] exp_rsp;
    logic [63:0] tms_seq, tdi_seq;
    int          nper, shift_rises;
    bit          first_pend, outstanding;
    logic [31:0] last_rsp;

    task automatic push(input logic tms, input logic tdi, input logic trst,
                        input logic shift, input int idx);
        per_t p;
        p.tms = tms; p.tdi = tdi; p.trst = trst; p.shift = shift; p.idx = idx;
        p.first = first_pend;
        first_pend = 1'b0;
        exp_q.push_back(p);
    endtask

    // Expected sequence of TCK periods for one command.
    task automatic build(input logic [1:0] op, input int len, input logic [31:0] data);
        int n;
        exp_q.delete();
        exp_rsp = '0; tms_seq = '0; tdi_seq = '0;
        nper = 0; shift_rises = 0; first_pend = 1'b1;
        case (op)
            OP_RESET: begin
                for (int i = 0; i < 5; i++) push(1'b1, 1'b0, 1'b0, 1'b0, 0);
                push(1'b0, 1'b0, 1'b1, 1'b0, 0);
            end
            OP_IDLE: for (int i = 0; i < len; i++) push(1'b0, 1'b0, 1'b1, 1'b0, 0);
            default: begin
                if (op == OP_IR) begin
                    n = IR_LEN;
                    push(1'b1, 1'b0, 1'b1, 1'b0, 0); push(1'b1, 1'b0, 1'b1, 1'b0, 0);
                    push(1'b0, 1'b0, 1'b1, 1'b0, 0); push(1'b0, 1'b0, 1'b1, 1'b0, 0);
                end else begin
                    n = (len == 0) ? 1 : (len > DR_MAX) ? DR_MAX : len;
                    push(1'b1, 1'b0, 1'b1, 1'b0, 0);
                    push(1'b0, 1'b0, 1'b1, 1'b0, 0); push(1'b0, 1'b0, 1'b1, 1'b0, 0);
                end
                for (int i = 0; i < n; i++) push(i == n - 1, data[i], 1'b1, 1'b1, i);
                push(1'b1, 1'b0, 1'b1, 1'b0, 0);
                push(1'b0, 1'b0, 1'b1, 1'b0, 0);
            end
        endcase
    endtask

    logic prev_tck, prev_tms, prev_tdi;
    int   run;
    per_t e;

    // Per-cycle compare process.
    initial begin
        prev_tck = 1'b0; prev_tms = 1'b0; prev_tdi = 1'b0; run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_tck = 1'b0;
                run = 0;
            end else begin
                if (TCK && !prev_tck) begin
                    chk("tck_rise_expected", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("tms", 64'(TMS), 64'(e.tms));
                        chk("tdi", 64'(TDI), 64'(e.tdi));
                        chk("trst", 64'(TRST), 64'(e.trst));
                        if (!e.first) chk("tck_low_len", 64'(run), 64'(CLK_DIV));
                        if (e.shift) begin
                            exp_rsp[e.idx] = TDO;
                            shift_rises++;
                        end
                    end
                    tms_seq = {tms_seq[62:0], TMS};
                    tdi_seq = {tdi_seq[62:0], TDI};
                    nper++;
                    run = 1;
                end else if (!TCK && prev_tck) begin
                    chk("tck_high_len", 64'(run), 64'(CLK_DIV));
                    run = 1;
                end else begin
                    if (TCK) begin
                        chk("tms_stable_high", 64'(TMS), 64'(prev_tms));
                        chk("tdi_stable_high", 64'(TDI), 64'(prev_tdi));
                    end
                    run++;
                end
                if (cmd_ready) begin
                    chk("idle_tck_low", 64'(TCK), 64'd0);
                    chk("idle_busy", 64'(busy), 64'd0);
                    chk("idle_tdi", 64'(TDI), 64'd0);
                end else begin
                    chk("busy_when_not_ready", 64'(busy), 64'd1);
                end
                if (!outstanding) chk("rsp_valid_without_cmd", 64'(rsp_valid), 64'd0);
                prev_tck = TCK; prev_tms = TMS; prev_tdi = TDI;
            end
        end
    end

    task automatic wait_ready(input string name);
        int k = 0;
        while (!cmd_ready && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_ready"}, 64'(cmd_ready), 64'd1);
    endtask

    task automatic send(input logic [1:0] op, input int len, input logic [31:0] data);
        wait_ready("send");
        build(op, len, data);
        cmd_valid = 1'b1; cmd_op = op; cmd_len = 6'(len); cmd_data = data;
        @(posedge clk);
        outstanding = 1'b1;
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("accept_clears_ready", 64'(cmd_ready), 64'd0);
    endtask

    task automatic wait_rsp(input string name);
        int k = 0;
        while (!rsp_valid && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
        chk({name, "_rsp_data"}, 64'(rsp_data), 64'(exp_rsp));
        chk({name, "_walk_done"}, 64'(exp_q.size()), 64'd0);
        last_rsp = rsp_data;
    endtask

    task automatic get_rsp(input string name);
        wait_rsp(name);
        @(negedge clk);
        chk({name, "_ready_after_rsp"}, 64'(cmd_ready), 64'd1);
        chk({name, "_rsp_dropped"}, 64'(rsp_valid), 64'd0);
        outstanding = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors + 1);
        $fatal(1);
    end

    initial begin
        outstanding = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tck", 64'(TCK), 64'd0);
        chk("rst_tms", 64'(TMS), 64'd1);
        chk("rst_tdi", 64'(TDI), 64'd0);
        chk("rst_trst", 64'(TRST), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);

        build(OP_RESET, 0, 32'd0);
        rst_n = 1'b1;
        wait_ready("init");
        chk("init_periods", 64'(nper), 64'd6);
        chk("init_tms_seq", tms_seq[5:0], 64'b111110);
        chk("init_walk_done", 64'(exp_q.size()), 64'd0);

        // Loopback DR shift: response equals shifted data.
        loop_mode = 1'b1;
        send(OP_DR, 8, 32'hA5);
        get_rsp("dr8");
        chk("dr8_rsp_lit", 64'(last_rsp), 64'h0000_00A5);
        chk("dr8_periods", 64'(nper), 64'd13);
        chk("dr8_tms_seq", tms_seq[12:0], 64'b1000000000110);
        chk("dr8_tdi_seq", tdi_seq[12:0], 64'b0001010010100);

        loop_mode = 1'b0;
        send(OP_IR, 0, 32'b0110);
        get_rsp("ir");
        chk("ir_periods", 64'(nper), 64'd10);
        chk("ir_tms_seq", tms_seq[9:0], 64'b1100000110);
        chk("ir_tdi_seq", tdi_seq[9:0], 64'b0000011000);
        chk("ir_rsp_upper", 64'(last_rsp[31:4]), 64'd0);

        send(OP_DR, 1, 32'h1);
        get_rsp("dr1");
        chk("dr1_periods", 64'(nper), 64'd6);

        send(OP_DR, 0, 32'hFFFF_FFFF);
        get_rsp("dr0");
        chk("dr0_periods", 64'(nper), 64'd6);
        chk("dr0_tdi_seq", tdi_seq[5:0], 64'b000100);
        chk("dr0_rsp_upper", 64'(last_rsp[31:1]), 64'd0);

        send(OP_DR, 40, 32'h1234_5678);
        get_rsp("dr40");
        chk("dr40_periods", 64'(nper), 64'd37);
        chk("dr40_shift_bits", 64'(shift_rises), 64'd32);

        send(OP_IDLE, 5, 32'hFFFF_FFFF);
        get_rsp("idle5");
        chk("idle5_rsp_lit", 64'(last_rsp), 64'd0);
        chk("idle5_periods", 64'(nper), 64'd5);
        chk("idle5_tms_seq", tms_seq[4:0], 64'd0);

        send(OP_IDLE, 0, 32'd0);
        get_rsp("idle0");
        chk("idle0_periods", 64'(nper), 64'd0);

        send(OP_RESET, 0, 32'hFFFF_FFFF);
        get_rsp("reset_op");
        chk("reset_op_rsp_lit", 64'(last_rsp), 64'd0);
        chk("reset_op_tms_seq", tms_seq[5:0], 64'b111110);

        // Back-pressure on the response side.
        loop_mode = 1'b1;
        rsp_ready = 1'b0;
        send(OP_DR, 8, 32'h3C);
        wait_rsp("bp");
        chk("bp_rsp_lit", 64'(last_rsp), 64'h3C);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid_held", 64'(rsp_valid), 64'd1);
            chk("bp_rsp_data_held", 64'(rsp_data), 64'h3C);
            chk("bp_cmd_ready_low", 64'(cmd_ready), 64'd0);
            chk("bp_tck_low", 64'(TCK), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_next_clk", 64'(cmd_ready), 64'd1);
        chk("bp_rsp_dropped", 64'(rsp_valid), 64'd0);
        outstanding = 1'b0;

        // Reset during bit 5 of a 16-bit DR shift.
        send(OP_DR, 16, 32'hBEEF);
        begin
            int k = 0;
            while (shift_rises < 5 && k < 2000) begin @(negedge clk); k++; end
            while (TCK && k < 2000) begin @(negedge clk); k++; end
            chk("midrst_reached_bit5", 64'(shift_rises), 64'd5);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_tck", 64'(TCK), 64'd0);
        chk("midrst_tms", 64'(TMS), 64'd1);
        chk("midrst_trst", 64'(TRST), 64'd0);
        chk("midrst_tdi", 64'(TDI), 64'd0);
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_rsp_data", 64'(rsp_data), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd1);
        outstanding = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        build(OP_RESET, 0, 32'd0);
        rst_n = 1'b1;
        wait_ready("reinit");
        chk("reinit_periods", 64'(nper), 64'd6);
        chk("reinit_tms_seq", tms_seq[5:0], 64'b111110);

        send(OP_DR, 4, 32'h9);
        get_rsp("post_rst");
        chk("post_rst_rsp_lit", 64'(last_rsp), 64'h9);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
`default_nettype wire
